// File: rtl/gcd_wb_host.sv
// Wishbone-slave register front end for the sequential GCD engine: holds operands,
// launches a job with a one-cycle load strobe, then captures the result or times out.
module gcd_wb_host #(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        gcd_load_o,
    output logic [31:0] gcd_a_o,
    output logic [31:0] gcd_b_o,
    input  logic        gcd_done_i,
    input  logic [31:0] gcd_result_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [7:0] OFF_A      = 8'h00;
    localparam logic [7:0] OFF_B      = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_RESULT = 8'h10;
    localparam logic [7:0] OFF_CYCLES = 8'h14;

    state_t      state;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] result;
    logic [31:0] cycles;
    logic        done;
    logic        timeout;
    logic        err;
    logic        irq_en;

    logic        hit;
    logic        req;
    logic        wr;
    logic [7:0]  offset;
    logic        busy;
    logic        wr_a;
    logic        wr_b;
    logic        wr_ctrl;
    logic        start_req;
    logic        clr_req;
    logic        illegal;
    logic [32:0] cyc_inc;
    logic [31:0] rdata;

    // A request is accepted only while ack is low, so each access acks exactly once.
    assign hit       = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
    assign wr        = req & wbs_we_i;
    assign offset    = wbs_adr_i[7:0];
    assign busy      = (state != IDLE);
    assign wr_a      = wr & (offset == OFF_A);
    assign wr_b      = wr & (offset == OFF_B);
    assign wr_ctrl   = wr & (offset == OFF_CTRL) & wbs_sel_i[0];
    assign start_req = wr_ctrl & wbs_dat_i[0];
    assign clr_req   = wr_ctrl & wbs_dat_i[2];
    assign illegal   = busy & (wr_a | wr_b | start_req);
    assign cyc_inc   = {1'b0, cycles} + 33'd1;

    assign gcd_a_o = reg_a;
    assign gcd_b_o = reg_b;
    assign irq_o   = irq_en & (done | timeout);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        rdata = 32'h0;
        case (offset)
            OFF_A:      rdata = reg_a;
            OFF_B:      rdata = reg_b;
            OFF_CTRL:   rdata = {30'b0, irq_en, 1'b0};
            OFF_STATUS: rdata = {28'b0, err, timeout, done, busy};
            OFF_RESULT: rdata = result;
            OFF_CYCLES: rdata = cycles;
            default:    rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'h0;
            gcd_load_o <= 1'b0;
            reg_a      <= 32'h0;
            reg_b      <= 32'h0;
            result     <= 32'h0;
            cycles     <= 32'h0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            wbs_ack_o  <= req;
            wbs_dat_o  <= (req && !wbs_we_i) ? rdata : 32'h0;
            gcd_load_o <= 1'b0;

            if (wr_a && !busy) reg_a <= merge_bytes(reg_a, wbs_dat_i, wbs_sel_i);
            if (wr_b && !busy) reg_b <= merge_bytes(reg_b, wbs_dat_i, wbs_sel_i);
            if (wr_ctrl) irq_en <= wbs_dat_i[1];

            // clr is applied first so a combined clr+start still launches the job.
            if (clr_req) begin
                done    <= 1'b0;
                timeout <= 1'b0;
                err     <= 1'b0;
            end
            if (illegal) err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_req) begin
                        state      <= LOAD;
                        gcd_load_o <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        cycles     <= 32'h0;
                    end
                end
                LOAD: state <= WAIT;
                WAIT: begin
                    if (!cyc_inc[32]) cycles <= cyc_inc[31:0];
                    // A done arriving on the timeout cycle still counts as success.
                    if (gcd_done_i) begin
                        result <= gcd_result_i;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else if (cyc_inc >= 33'(TIMEOUT_CYC)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_wb_host.sv
// Bench for gcd_wb_host: Wishbone driver tasks, a delay-programmable engine model,
// vector table, directed corner sequences and randomized jobs against a reference model.
module tb_gcd_wb_host;
  localparam int          TO        = 16;
  localparam logic [31:0] BASE      = 32'h3000_0000;
  localparam logic [31:0] ADR_A     = BASE + 32'h00;
  localparam logic [31:0] ADR_B     = BASE + 32'h04;
  localparam logic [31:0] ADR_CTRL  = BASE + 32'h08;
  localparam logic [31:0] ADR_STAT  = BASE + 32'h0C;
  localparam logic [31:0] ADR_RES   = BASE + 32'h10;
  localparam logic [31:0] ADR_CYC   = BASE + 32'h14;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        gcd_load_o;
  logic [31:0] gcd_a_o, gcd_b_o;
  logic        eng_done;
  logic [31:0] eng_res;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  int   eng_delay = 3;
  bit   eng_on    = 1'b1;
  bit   eng_busy  = 1'b0;
  int   load_cnt  = 0;
  logic irq_en_tb = 1'b0;
  logic [31:0] last_res = 32'h0;

  gcd_wb_host #(.ADDR_BASE(BASE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .gcd_load_o(gcd_load_o), .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
    .gcd_done_i(eng_done), .gcd_result_i(eng_res), .irq_o(irq_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // load pulses counted once per cycle they are high
  always @(negedge clk) if (gcd_load_o) load_cnt++;

  // engine model: answers each load after eng_delay WAIT cycles
  initial begin
    logic [31:0] la, lb;
    int d;
    eng_done = 1'b0;
    eng_res  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (gcd_load_o && eng_on) begin
        eng_busy = 1'b1;
        la = gcd_a_o;
        lb = gcd_b_o;
        d  = eng_delay;
        repeat (d) @(posedge clk);
        #1;
        eng_done = 1'b1;
        eng_res  = ref_gcd(la, lb);
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        eng_res  = $urandom;
        eng_busy = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rd = wbs_dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic ok;
    wb_xfer(a, 1'b1, d, s, rd, ok);
    check("write_ack", 32'(ok), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic ok;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, d, ok);
    check("read_ack", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int k;
    k = 0;
    st = 32'h1;
    while (st[0] && k < 100) begin
      wb_read(ADR_STAT, st);
      k++;
    end
    check("job_finished", 32'(st[0]), 32'd0);
    while (eng_busy) @(posedge clk);
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] b, input int d, input bit en);
    eng_delay = d;
    eng_on = en;
    wb_write(ADR_A, a, 4'hF);
    wb_write(ADR_B, b, 4'hF);
    wb_write(ADR_CTRL, {30'b0, irq_en_tb, 1'b1}, 4'hF);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    logic [31:0] res;
    logic [31:0] st;
    logic [31:0] cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] rd, ra, rb;
    logic ok;
    int lc, d;
    logic [31:0] regs[6];

    vecs[0] = '{32'd48,   32'd18,  3,  32'd6,  32'h2, 32'd3};
    vecs[1] = '{32'd17,   32'd5,   4,  32'd1,  32'h2, 32'd4};
    vecs[2] = '{32'd0,    32'd35,  1,  32'd35, 32'h2, 32'd1};
    vecs[3] = '{32'd0,    32'd0,   2,  32'd0,  32'h2, 32'd2};
    vecs[4] = '{32'd1071, 32'd462, 16, 32'd21, 32'h2, 32'd16};
    vecs[5] = '{32'd100,  32'd75,  7,  32'd25, 32'h2, 32'd7};

    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_load", 32'(gcd_load_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    regs = '{ADR_A, ADR_B, ADR_CTRL, ADR_STAT, ADR_RES, ADR_CYC};
    for (int i = 0; i < 6; i++) begin
      wb_read(regs[i], rd);
      check("rst_reg", rd, 32'h0);
    end

    // vector table (includes done on the exact timeout cycle)
    for (int i = 0; i < 6; i++) begin
      lc = load_cnt;
      start_job(vecs[i].a, vecs[i].b, vecs[i].delay, 1'b1);
      wait_idle();
      check("vec_load_pulses", 32'(load_cnt - lc), 32'd1);
      wb_read(ADR_RES, rd);  check("vec_result", rd, vecs[i].res);
      wb_read(ADR_STAT, rd); check("vec_status", rd, vecs[i].st);
      wb_read(ADR_CYC, rd);  check("vec_cycles", rd, vecs[i].cyc);
      last_res = vecs[i].res;
    end

    // irq enable, rise with done, clear
    wb_write(ADR_CTRL, 32'h2, 4'hF);
    irq_en_tb = 1'b1;
    wb_read(ADR_CTRL, rd);
    check("ctrl_read", rd, 32'h2);
    check("irq_before_clear", 32'(irq_o), 32'd1);
    start_job(32'd17, 32'd5, 5, 1'b1);
    check("irq_drop_on_start", 32'(irq_o), 32'd0);
    wait_idle();
    check("irq_on_done", 32'(irq_o), 32'd1);
    wb_read(ADR_RES, rd); check("irq_result", rd, 32'd1);
    last_res = 32'd1;
    wb_write(ADR_CTRL, 32'h6, 4'hF);
    #1;
    check("irq_after_clr", 32'(irq_o), 32'd0);
    wb_read(ADR_STAT, rd); check("status_after_clr", rd, 32'h0);

    // engine silent: timeout
    lc = load_cnt;
    start_job(32'd5, 32'd10, 1, 1'b0);
    wait_idle();
    check("to_load_pulses", 32'(load_cnt - lc), 32'd1);
    check("to_irq", 32'(irq_o), 32'd1);
    wb_read(ADR_STAT, rd); check("to_status", rd, 32'h4);
    wb_read(ADR_CYC, rd);  check("to_cycles", rd, 32'd16);
    wb_read(ADR_RES, rd);  check("to_result_kept", rd, last_res);
    wb_write(ADR_CTRL, 32'h4, 4'hF);
    irq_en_tb = 1'b0;
    check("irq_disabled", 32'(irq_o), 32'd0);

    // writes while busy are rejected
    lc = load_cnt;
    start_job(32'd48, 32'd18, 12, 1'b1);
    wb_write(ADR_A, 32'd99, 4'hF);
    wb_write(ADR_CTRL, 32'h1, 4'hF);
    wait_idle();
    check("busy_load_pulses", 32'(load_cnt - lc), 32'd1);
    wb_read(ADR_A, rd);    check("busy_a_kept", rd, 32'd48);
    wb_read(ADR_STAT, rd); check("busy_status", rd, 32'hA);
    wb_read(ADR_RES, rd);  check("busy_result", rd, 32'd6);
    wb_read(ADR_CYC, rd);  check("busy_cycles", rd, 32'd12);
    last_res = 32'd6;
    wb_write(ADR_CTRL, 32'h4, 4'hF);
    wb_read(ADR_STAT, rd); check("err_cleared", rd, 32'h0);

    // byte enables, unmapped offsets, window misses
    wb_write(ADR_A, 32'h0, 4'hF);
    wb_write(ADR_A, 32'hAABB_CCDD, 4'b0001);
    wb_read(ADR_A, rd); check("sel_low_byte", rd, 32'h0000_00DD);
    wb_write(ADR_A, 32'h1122_3344, 4'b0110);
    wb_read(ADR_A, rd); check("sel_mid_bytes", rd, 32'h0022_33DD);
    wb_xfer(BASE + 32'h20, 1'b0, 32'h0, 4'hF, rd, ok);
    check("unmapped_ack", 32'(ok), 32'd1);
    check("unmapped_data", rd, 32'h0);
    wb_xfer(BASE + 32'h100, 1'b0, 32'h0, 4'hF, rd, ok);
    check("miss_read_noack", 32'(ok), 32'd0);
    wb_xfer(32'h3100_0000, 1'b1, 32'h55, 4'hF, rd, ok);
    check("miss_write_noack", 32'(ok), 32'd0);
    wb_read(ADR_A, rd); check("miss_write_ignored", rd, 32'h0022_33DD);
    lc = load_cnt;
    wb_write(ADR_CTRL, 32'h1, 4'b1110);
    repeat (3) @(posedge clk);
    check("ctrl_needs_sel0", 32'(load_cnt - lc), 32'd0);

    // reset in the middle of a job
    start_job(32'd48, 32'd18, 10, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", gcd_a_o, 32'h0);
    check("mid_rst_b", gcd_b_o, 32'h0);
    check("mid_rst_load", 32'(gcd_load_o), 32'd0);
    check("mid_rst_ack", 32'(wbs_ack_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lc = load_cnt;
    while (eng_busy) @(posedge clk);
    repeat (2) @(posedge clk);
    check("no_load_after_rst", 32'(load_cnt - lc), 32'd0);
    wb_read(ADR_STAT, rd); check("late_done_status", rd, 32'h0);
    wb_read(ADR_RES, rd);  check("late_done_result", rd, 32'h0);
    start_job(32'd48, 32'd18, 3, 1'b1);
    wait_idle();
    wb_read(ADR_RES, rd); check("post_rst_result", rd, 32'd6);
    last_res = 32'd6;

    // randomized jobs against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom_range(0, 5000);
      rb = $urandom_range(0, 5000);
      d = $urandom_range(1, 20);
      irq_en_tb = 1'($urandom_range(0, 1));
      if (d <= TO) exp_q.push_back(ref_gcd(ra, rb));
      else exp_q.push_back(last_res);
      start_job(ra, rb, d, 1'b1);
      wait_idle();
      last_res = exp_q[0];
      wb_read(ADR_RES, rd);  check("rand_result", rd, exp_q.pop_front());
      wb_read(ADR_STAT, rd); check("rand_status", rd, (d <= TO) ? 32'h2 : 32'h4);
      wb_read(ADR_CYC, rd);  check("rand_cycles", rd, (d <= TO) ? 32'(d) : 32'(TO));
      check("rand_irq", 32'(irq_o), 32'(irq_en_tb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
